// File: rtl/load_pkg.sv
// Shared encodings for the MEM-stage load sequencer.
// Load opcodes, FSM states and the timeout counter width helper.
`timescale 1ns/1ps
package load_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam int TIMEOUT_DEF = 16;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/halfword select and sign/zero extension of a read word.
// Little-endian lane select by the latched address offset.
`timescale 1ns/1ps
module load_extend
  import load_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_op)
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'd0, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_ext_ctrl.sv
// MEM-stage load sequencer: word read handshake, extension, stall.
// Optional bus timeout abort when LOAD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module load_ext_ctrl
  import load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [2:0]  ld_op,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_done,
  output logic        misalign_exc,
  output logic [31:0] bad_addr,
  output logic        bus_err
);

  state_e      r_state;
  state_e      w_next;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic        r_drop;
  logic [31:0] r_ld_data;
  logic [31:0] w_ext;
  logic        w_legal;
  logic        w_mis;
  logic        w_idle;
  logic        w_busy;
  logic        w_accept;
  logic        w_ack;
  logic        w_abort;

  assign w_legal = ld_op inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};
  assign w_mis   = ((ld_op == LD_LH || ld_op == LD_LHU) && addr[0])
                 || (ld_op == LD_LW && addr[1:0] != 2'b00);
  assign w_idle  = (r_state == S_IDLE);
  assign w_busy  = (r_state == S_BUSY);
  assign w_accept = w_idle & ld_valid & w_legal & ~w_mis & ~flush;
  assign w_ack   = w_busy & mem_ack;

`ifdef LOAD_TIMEOUT_EN
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;

  assign w_abort = w_busy & ~mem_ack
                 & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_accept)
        r_cnt <= '0;
      else if (w_busy && !mem_ack && !w_abort)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_abort = 1'b0;
  assign bus_err = 1'b0;
`endif

  load_extend u_ext (
    .i_word (mem_rdata),
    .i_op   (r_op),
    .i_off  (r_off),
    .o_data (w_ext)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_BUSY;
      S_BUSY: begin
        if (mem_ack)
          w_next = (r_drop || flush) ? S_IDLE : S_DONE;
        else if (w_abort)
          w_next = S_IDLE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_op       <= LD_LW;
      r_off      <= 2'b00;
      r_drop     <= 1'b0;
      r_ld_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= {addr[31:2], 2'b00};
        r_op       <= ld_op;
        r_off      <= addr[1:0];
        r_drop     <= 1'b0;
      end else if (w_ack || w_abort) begin
        r_mem_req <= 1'b0;
      end
      // A squash mid-handshake only suppresses the writeback
      if (w_busy && flush)
        r_drop <= 1'b1;
      if (w_ack)
        r_ld_data <= w_ext;
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign ld_data      = r_ld_data;
  assign stall        = w_accept | w_busy;
  assign ld_done      = (r_state == S_DONE) & ~flush;
  assign misalign_exc = w_idle & ld_valid & w_legal & w_mis & ~flush;
  assign bad_addr     = addr;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Directed scoreboard bench for load_ext_ctrl.
// Build with LOAD_TIMEOUT_EN to also exercise the timeout abort.
`timescale 1ns/1ps
module tb_load_ext_ctrl;

`ifdef LOAD_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_op = 3'b000;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        misalign_exc;
  logic [31:0] bad_addr;
  logic        bus_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  load_ext_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_op        (ld_op),
    .addr         (addr),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .ld_data      (ld_data),
    .ld_done      (ld_done),
    .misalign_exc (misalign_exc),
    .bad_addr     (bad_addr),
    .bus_err      (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a[1:0], 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      3'b011:  return w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_load(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] rd, input int delay,
                         input int flush_at, input bit exp_done,
                         output int stalls, output int reqs,
                         output int done_cyc, output logic [31:0] maddr);
    bit brk;
    bit ok;
    stalls = 0; reqs = 0; done_cyc = -1; maddr = '0; ok = 0;
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_op = op; addr = a;
    if (exp_done) sb_q.push_back(ref_ext(op, a, rd));
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (mem_req) begin reqs++; maddr = mem_addr; end
      if (ld_done) begin
        done_cyc = cyc;
        if (sb_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
        else chk("ld_data", ld_data, sb_q.pop_front());
      end
      brk = (stalls > 0) && !stall;
      mem_ack = mem_req && (reqs == delay + 1);
      mem_rdata = mem_ack ? rd : $urandom;
      flush = (flush_at >= 0) && mem_req && (reqs == flush_at + 1);
      if (mem_ack && flush_at >= 0) ld_valid = 1'b0;
      if (brk) begin ok = 1; break; end
    end
    if (!ok) chk("load_timeout", 32'd1, 32'd0);
    mem_ack = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  int s, r, d;
  logic [31:0] ma;
  logic [31:0] held;
  int seen;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_load(3'b000, 32'h1003, 32'h80FF_1234, 0, -1, 1, s, r, d, ma);
    chk("lb_mem_addr", ma, 32'h1000);
    chk("lb_stall_cycles", s, 2);
    chk("lb_req_cycles", r, 1);
    chk("lb_done_cycle", d, 2);

    do_load(3'b101, 32'h2002, 32'h9ABC_5678, 4, -1, 1, s, r, d, ma);
    chk("lhu_req_cycles", r, 5);
    chk("lhu_mem_addr", ma, 32'h2000);
    chk("lhu_ld_data", ld_data, 32'h0000_9ABC);

    @(posedge clk); #1;
    ld_valid = 1'b1; ld_op = 3'b011; addr = 32'h3001;
    @(negedge clk);
    chk("lw_mis_exc", {31'd0, misalign_exc}, 32'd1);
    chk("lw_bad_addr", bad_addr, 32'h3001);
    chk("lw_mis_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
    ld_op = 3'b001; addr = 32'h3003;
    #1 chk("lh_mis_exc", {31'd0, misalign_exc}, 32'd1);
    ld_op = 3'b000;
    #1 chk("lb_never_mis", {31'd0, misalign_exc}, 32'd0);
    ld_valid = 1'b0;

    do_load(3'b001, 32'h0, 32'h1111_8000, 3, 1, 0, s, r, d, ma);
    chk("flush_req_cycles", r, 4);
    chk("flush_no_done", d, -1);
    chk("flush_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);

    @(posedge clk); #1;
    ld_valid = 1'b1; ld_op = 3'b001; addr = 32'h10;
    repeat (2) @(negedge clk);
    chk("rst_mid_req_hi", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0; ld_valid = 1'b0;
    #1 chk("rst_mid_req_lo", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", {31'd0, stall}, 32'd0);
    do_load(3'b100, 32'h4001, 32'h0000_FF00, 1, -1, 1, s, r, d, ma);
    chk("lbu_value", ld_data, 32'h0000_00FF);

    do_load(3'b001, 32'h5002, 32'h8001_0000, 2, -1, 1, s, r, d, ma);
    chk("lh_neg", ld_data, 32'hFFFF_8001);
    do_load(3'b011, 32'h6000, 32'hDEAD_BEEF, 0, -1, 1, s, r, d, ma);
    chk("lw_done_cycle", d, 2);

    @(posedge clk); #1;
    ld_valid = 1'b1; ld_op = 3'b010; addr = 32'h7001;
    @(negedge clk);
    chk("undef_stall", {31'd0, stall}, 32'd0);
    chk("undef_exc", {31'd0, misalign_exc}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("undef_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_data", ld_data, 32'hDEAD_BEEF);
    chk("stray_ack_done", {31'd0, ld_done}, 32'd0);
    mem_ack = 1'b0; ld_valid = 1'b0;

`ifdef LOAD_TIMEOUT_EN
    held = ld_data;
    seen = 0;
    r = 0;
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_op = 3'b011; addr = 32'h8000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_err) begin seen = 1; break; end
      if (mem_req) r++;
      if (r == TO) ld_valid = 1'b0;
    end
    chk("to_bus_err_seen", seen, 1);
    chk("to_busy_cycles", r, TO);
    chk("to_stall_drop", {31'd0, stall}, 32'd0);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_ld_data", ld_data, held);
    @(negedge clk);
    chk("to_pulse_1cyc", {31'd0, bus_err}, 32'd0);
`else
    chk("no_to_bus_err", {31'd0, bus_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_ext_ctrl.md
Name: load_ext_ctrl

Overview:
- MEM-stage load sequencer for the pipelined MIPS core.
- Accepts one load from the pipeline and issues a word-aligned req/ack read to data memory.
- Selects the byte or halfword from the returned word and sign- or zero-extends it to 32 bits.
- Stalls the pipeline until data is ready and flags misaligned addresses.

Parameters:
- TIMEOUT_CYCLES, 16, BUSY cycles without mem_ack before abort (used only with LOAD_TIMEOUT_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  MEM stage holds a load; held stable while stall=1.
- ld_op  in  3  load type, MIPS opcode[2:0]: LB=000, LH=001, LW=011, LBU=100, LHU=101.
- addr  in  32  effective byte address.
- flush  in  1  squash the current load.
- mem_req  out  1  read request to data memory.
- mem_addr  out  32  {addr[31:2],2'b00}, latched.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  read word.
- stall  out  1  freeze IF..MEM.
- ld_data  out  32  extended load result.
- ld_done  out  1  ld_data valid for WB this cycle.
- misalign_exc  out  1  address-error exception.
- bad_addr  out  32  faulting address.
- bus_err  out  1  timeout abort pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req=0, mem_addr=0, ld_data=0, ld_done=0, stall=0, misalign_exc=0, bus_err=0. Reset mid-transaction drops mem_req immediately.
- FSM states: IDLE, BUSY, DONE.
- misaligned = (LH|LHU & addr[0]) | (LW & addr[1:0]!=0). Byte loads are never misaligned.
- Undefined ld_op codes are no-ops: no request, no stall, no exception.
- IDLE:
  - accept = ld_valid & legal op & !misaligned & !flush.
  - stall = accept, combinational.
  - On accept: latch op, addr[1:0], and mem_addr; state goes to BUSY.
  - misalign_exc = ld_valid & legal op & misaligned & !flush, combinational; bad_addr = addr. No stall, no request.
- BUSY:
  - mem_req=1 (registered) and stall=1.
  - mem_addr is stable until ack.
  - On mem_ack: mem_req=0 next cycle; ld_data <= extended data; state goes to DONE, or to IDLE if the drop flag is set.
  - flush in BUSY sets the drop flag. The handshake is never abandoned.
  - mem_ack outside BUSY is ignored.
- DONE (one cycle):
  - stall=0; ld_done = !flush.
  - Pipeline advances at the end of this cycle.
  - Always returns to IDLE. A load cannot be re-accepted in DONE.
- Minimum latency: accept cycle + 1 BUSY cycle with ack + DONE = 3 cycles.
- Extraction is little-endian by latched offset:
  - LB/LBU: byte at offset (off=0 -> [7:0] ... off=3 -> [31:24]).
  - LH/LHU: off[1]=0 -> [15:0], off[1]=1 -> [31:16].
  - LB/LH replicate the MSB into the upper bits; LBU/LHU zero-fill.
- ld_data holds its value until the next ack.

Optional Feature:
- LOAD_TIMEOUT_EN defined:
  - Counter cleared on BUSY entry, incremented on each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: mem_req=0, bus_err pulses 1 cycle, state goes to IDLE, ld_data unchanged, ld_done stays 0.
  - Ack in the same cycle as the limit wins; no error is raised.
- LOAD_TIMEOUT_EN undefined:
  - No counter; bus_err tied 0.
  - BUSY waits indefinitely.

Decomposition:
- load_pkg:
  - ld_op encodings (LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU).
  - State enum (S_IDLE, S_BUSY, S_DONE).
  - Timeout counter width, $clog2(TIMEOUT_CYCLES).
- Sub-module load_extend: purely combinational (word, op, offset) -> 32-bit extended result, reused by the FSM top.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80FF_1234, ack one cycle after req:
  - mem_addr=0x1000.
  - ld_data=0xFFFF_FF80; ld_done on the 3rd cycle.
  - stall high for exactly 2 cycles.
- LHU, addr=0x2002, rdata=0x9ABC_5678, ack delayed 4 cycles: ld_data=0x0000_9ABC; mem_req held 5 cycles.
- LW, addr=0x3001: misalign_exc=1, bad_addr=0x3001 same cycle; mem_req stays 0; no stall.
- LH, addr=0x0, flush asserted in the 2nd BUSY cycle, ack later: handshake completes, ld_done stays 0, FSM back to IDLE.
- rst_n low during BUSY with mem_req=1: mem_req=0 asynchronously; FSM in IDLE after release; a following LBU of 0xFF returns 0x0000_00FF.
- With LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never given: bus_err pulses after 4 BUSY cycles, stall drops, ld_data unchanged.
